// File: rtl/dna_pkg.sv
// Shared types for the DNA identifier port and its comparison client.
package dna_pkg;
   localparam int DNA_WIDTH = 57;
   typedef logic [DNA_WIDTH-1:0] dna_t;
   localparam dna_t DNA_DEFAULT = 57'h000094c94546a85c;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } check_state_e;
endpackage

// File: rtl/dna_port_model_if.sv
// Serial DNA port signals; the client (master) drives read/shift/din, the port (slave) returns dout.
// Protocol: no handshake. Every cycle is a command: read=1 loads, else shift=1 shifts, else hold.
interface dna_port_model_if;
   logic read;
   logic shift;
   logic din;
   logic dout;

   modport master (output read, output shift, output din, input dout);
   modport slave (input read, input shift, input din, output dout);
endinterface

// File: rtl/dna_check.sv
// DNA comparison client: pulses read once, then shifts 57 bits and compares them to an expected value.
module dna_check
   import dna_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  dna_t               expected,
   dna_port_model_if.master   port,
   output logic               done,
   output logic               match,
   output check_state_e       state
);

   check_state_e next_state;
   logic [5:0]   idx;
   logic         mis;
   logic         bit_mis;

   assign bit_mis = (port.dout != expected[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // DOUT is sampled on each shift edge, so bit idx is visible before the edge that shifts it out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         mis   <= 1'b0;
         match <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  match <= 1'b0;
               end
            end
            ST_LOAD: begin
               idx <= 6'(DNA_WIDTH - 1);
               mis <= 1'b0;
            end
            ST_SHIFT: begin
               if (bit_mis) begin
                  mis <= 1'b1;
               end
               idx <= idx - 6'd1;
               if (idx == 6'd0) begin
                  match <= ~(mis | bit_mis);
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      next_state = state;
      port.read  = 1'b0;
      port.shift = 1'b0;
      port.din   = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            port.read  = 1'b1;
            next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            port.shift = 1'b1;
            if (idx == 6'd0) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/dna_port_model.sv
// Behavioural DNA_PORT stand-in: parallel-load a fixed 57-bit identifier, shift it out MSB-first.
module dna_port_model
   import dna_pkg::*;
#(
   parameter dna_t SIM_DNA_VALUE = DNA_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic READ,
   input  logic SHIFT,
   input  logic DIN,
   output logic DOUT
);

   dna_t sr;

   generate
      if ($bits(SIM_DNA_VALUE) != DNA_WIDTH) begin : g_width_check
         $error("SIM_DNA_VALUE must be exactly DNA_WIDTH bits wide");
      end
   endgenerate

   // READ wins over SHIFT so a reload mid-stream always restarts from bit 56.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (READ) begin
         sr <= SIM_DNA_VALUE;
      end else if (SHIFT) begin
         sr <= {sr[DNA_WIDTH-2:0], DIN};
      end
   end

   assign DOUT = sr[DNA_WIDTH-1];

endmodule

// File: tb/tb_dna_port_model.sv
// Self-checking bench for dna_port_model and its dna_check client.
module tb_dna_port_model;
   import dna_pkg::*;

   localparam dna_t SIM = DNA_DEFAULT;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         tb_read, tb_shift, tb_din, use_client;
   logic         dout;
   logic         start;
   dna_t         expected;
   logic         done, match;
   check_state_e ck_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the register is a queue of bits, front = the bit currently on DOUT.
   logic exp_q[$];

   always #5 clk = ~clk;

   dna_port_model_if ck_if ();

   dna_port_model #(.SIM_DNA_VALUE(SIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .READ  (use_client ? ck_if.read  : tb_read),
      .SHIFT (use_client ? ck_if.shift : tb_shift),
      .DIN   (use_client ? ck_if.din   : tb_din),
      .DOUT  (dout)
   );

   assign ck_if.dout = dout;

   dna_check u_check (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .expected (expected),
      .port     (ck_if),
      .done     (done),
      .match    (match),
      .state    (ck_state)
   );

   function automatic void model_reset();
      exp_q.delete();
      for (int i = 0; i < DNA_WIDTH; i++) exp_q.push_back(1'b0);
   endfunction

   function automatic void model_load();
      exp_q.delete();
      for (int i = DNA_WIDTH - 1; i >= 0; i--) exp_q.push_back(SIM[i]);
   endfunction

   function automatic void model_shift(input logic d);
      void'(exp_q.pop_front());
      exp_q.push_back(d);
   endfunction

   // One clock: inputs applied before the edge, model stepped at the edge, return 1 ns after it.
   task automatic cycle(input logic rd, input logic sh, input logic di);
      tb_read  = rd;
      tb_shift = sh;
      tb_din   = di;
      @(posedge clk);
      if (rd) model_load();
      else if (sh) model_shift(di);
      #1;
   endtask

   task automatic test_reset();
      int guard;
      n_checks++;
      if (dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", dout);
      else n_pass++;
      n_checks++;
      if (ck_state !== ST_IDLE) $display("FAIL reset_client_state: got %0d want %0d", ck_state, ST_IDLE);
      else n_pass++;
      cycle(1'b1, 1'b0, 1'b0);
      guard = 0;
      while (exp_q[0] !== 1'b1 && guard < DNA_WIDTH) begin
         cycle(1'b0, 1'b1, 1'b1);
         guard++;
      end
      n_checks++;
      if (dout !== 1'b1) $display("FAIL pre_reset_dout: got %b want 1", dout);
      else n_pass++;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (dout !== 1'b0) $display("FAIL async_reset_dout: got %b want 0", dout);
      else n_pass++;
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         n_checks++;
         if (dout !== 1'b0) $display("FAIL post_reset_idle[%0d]: got %b want 0", i, dout);
         else n_pass++;
      end
   endtask

   task automatic test_load();
      dna_t got;
      cycle(1'b1, 1'b0, 1'b0);
      got[DNA_WIDTH-1] = dout;
      n_checks++;
      if (dout !== SIM[DNA_WIDTH-1]) $display("FAIL load_bit56: got %b want %b", dout, SIM[DNA_WIDTH-1]);
      else n_pass++;
      for (int k = 1; k < DNA_WIDTH; k++) begin
         cycle(1'b0, 1'b1, 1'b0);
         got[DNA_WIDTH-1-k] = dout;
         n_checks++;
         if (dout !== exp_q[0]) $display("FAIL load_shift[%0d]: got %b want %b", k, dout, exp_q[0]);
         else n_pass++;
      end
      n_checks++;
      if (got !== SIM) $display("FAIL load_reconstruct: got %h want %h", got, SIM);
      else n_pass++;
   endtask

   task automatic test_priority();
      cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      n_checks++;
      if (dout !== SIM[DNA_WIDTH-11]) $display("FAIL prio_before: got %b want %b", dout, SIM[DNA_WIDTH-11]);
      else n_pass++;
      cycle(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (dout !== SIM[DNA_WIDTH-1]) $display("FAIL prio_reload: got %b want %b", dout, SIM[DNA_WIDTH-1]);
      else n_pass++;
      cycle(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (dout !== SIM[DNA_WIDTH-2]) $display("FAIL prio_no_shift: got %b want %b", dout, SIM[DNA_WIDTH-2]);
      else n_pass++;
   endtask

   task automatic test_rollover();
      logic d;
      cycle(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= DNA_WIDTH; k++) begin
         cycle(1'b0, 1'b1, 1'b1);
         n_checks++;
         if (dout !== exp_q[0]) $display("FAIL roll_ones[%0d]: got %b want %b", k, dout, exp_q[0]);
         else n_pass++;
      end
      n_checks++;
      if (dout !== 1'b1) $display("FAIL roll_ones_57: got %b want 1", dout);
      else n_pass++;
      for (int k = 1; k <= DNA_WIDTH; k++) cycle(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (dout !== 1'b0) $display("FAIL roll_zeros_57: got %b want 0", dout);
      else n_pass++;
      // Loop-back: after 57 rotations the identifier is back in place.
      cycle(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= DNA_WIDTH; k++) begin
         d = dout;
         cycle(1'b0, 1'b1, d);
         n_checks++;
         if (dout !== SIM[(2 * DNA_WIDTH - 1 - k) % DNA_WIDTH])
            $display("FAIL loopback[%0d]: got %b want %b", k, dout, SIM[(2 * DNA_WIDTH - 1 - k) % DNA_WIDTH]);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         n_checks++;
         if (dout !== SIM[51]) $display("FAIL hold[%0d]: got %b want %b", k, dout, SIM[51]);
         else n_pass++;
      end
      cycle(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (dout !== SIM[50]) $display("FAIL hold_resume: got %b want %b", dout, SIM[50]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic rd, sh, di;
      for (int n = 0; n < 400; n++) begin
         rd = ($urandom_range(0, 9) == 0);
         sh = ($urandom_range(0, 9) < 7);
         di = 1'($urandom_range(0, 1));
         cycle(rd, sh, di);
         if ($urandom_range(0, 39) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1;
            #2 rst_n = 1'b1;
         end
         n_checks++;
         if (dout !== exp_q[0]) $display("FAIL random[%0d]: got %b want %b", n, dout, exp_q[0]);
         else n_pass++;
      end
   endtask

   task automatic run_client(input dna_t exp_val, input string name);
      int   budget;
      logic seen_match;
      logic want;
      want       = (exp_val == SIM);
      expected   = exp_val;
      seen_match = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      budget = 0;
      while (!done && budget < 200) begin
         if (match === 1'b1) seen_match = 1'b1;
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (!done) $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
      else n_pass++;
      n_checks++;
      if (match !== want) $display("FAIL %s_match: got %b want %b", name, match, want);
      else n_pass++;
      if (!want) begin
         n_checks++;
         if (seen_match) $display("FAIL %s_spurious_match: got 1 during run want 0", name);
         else n_pass++;
      end
   endtask

   task automatic test_client();
      dna_t v;
      use_client = 1'b1;
      run_client(SIM, "client_exact");
      v = SIM;
      v[0] = ~v[0];
      run_client(v, "client_bit0");
      for (int r = 0; r < 4; r++) begin
         v = SIM;
         if ($urandom_range(0, 1) == 1) begin
            int p;
            p = $urandom_range(0, DNA_WIDTH - 1);
            v[p] = ~v[p];
         end
         run_client(v, "client_rand");
      end
      use_client = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      tb_read    = 1'b0;
      tb_shift   = 1'b0;
      tb_din     = 1'b0;
      use_client = 1'b0;
      start      = 1'b0;
      expected   = '0;
      model_reset();
      #12 rst_n = 1'b1;
      #1;
      test_reset();
      test_load();
      test_priority();
      test_rollover();
      test_hold();
      test_random();
      test_client();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
